// File: rtl/idu_pkg.sv
// Shared decode types, opcode map, ALU and writeback-select encodings for the
// instruction decode stage.
package idu_pkg;

    // Bundle datapath fields are sized for the widest legal XLEN; narrower
    // builds zero-extend pc/imm/src values into them.
    localparam int unsigned BUNDLE_XLEN  = 64;
    localparam int unsigned ALU_OP_MAX_W = 8;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam logic [31:0] INST_ECALL = 32'h0000_0073;
    localparam logic [31:0] INST_MRET  = 32'h3020_0073;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_LUI  = 4'd10;

    localparam logic [1:0] RD_SEL_ALU = 2'd0;
    localparam logic [1:0] RD_SEL_LSU = 2'd1;
    localparam logic [1:0] RD_SEL_CSR = 2'd2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    typedef struct packed {
        logic [BUNDLE_XLEN-1:0]  pc;
        logic [BUNDLE_XLEN-1:0]  imm;
        logic [BUNDLE_XLEN-1:0]  src1;
        logic [BUNDLE_XLEN-1:0]  src2;
        logic [ALU_OP_MAX_W-1:0] alu_op;
        logic [4:0]              rd_addr;
        logic                    rd_wen;
        logic [1:0]              rd_sel;
        logic                    lsu_ren;
        logic                    lsu_wen;
        logic [2:0]              lsu_op;
        logic [11:0]             csr_addr;
        logic                    csr_wen;
        logic [2:0]              csr_sel;
        logic                    is_ecall;
        logic                    is_mret;
        logic                    is_branch;
        logic                    is_jump;
        logic                    illegal;
    } decode_bundle_t;

    // Integer ALU op from funct3; alt selects SUB/SRA on the shared encodings.
    function automatic logic [3:0] alu_from_funct3(input logic [2:0] funct3, input logic alt);
        logic [3:0] op;
        case (funct3)
            3'd0:    op = alt ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = alt ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/idu_imm_gen.sv
// Immediate generator: picks the I/S/B/U/J layout from the opcode and
// sign-extends the 32-bit result to XLEN.
module idu_imm_gen
    import idu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (inst[6:0])
            OP_JALR, OP_LOAD, OP_IMM, OP_SYSTEM, OP_FENCE:
                imm32 = {{20{inst[31]}}, inst[31:20]};
            OP_STORE:
                imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            OP_BRANCH:
                imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm32 = {inst[31:12], 12'b0};
            OP_JAL:
                imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/idu_pipe.sv
// Decode stage with valid/ready handshakes; IDU_PIPE_SKID_EN selects a
// 2-entry skid buffer (registered in_ready), otherwise a single pipeline entry.
module idu_pipe
    import idu_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ALU_OP_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output decode_bundle_t  out_bundle,
    output logic [1:0]      out_count
);

    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic [XLEN-1:0]     imm;
    logic [ALU_OP_W-1:0] alu_op;
    decode_bundle_t      dec;

    assign opcode   = in_inst[6:0];
    assign funct3   = in_inst[14:12];
    assign rs1_addr = in_inst[19:15];
    assign rs2_addr = in_inst[24:20];

    idu_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst (in_inst),
        .imm  (imm)
    );

    // Combinational decode of the word on in_inst; captured on in-fire.
    always_comb begin
        dec          = '0;
        alu_op       = ALU_OP_W'(ALU_ADD);
        dec.pc       = BUNDLE_XLEN'(in_pc);
        dec.imm      = BUNDLE_XLEN'(imm);
        dec.src1     = BUNDLE_XLEN'(rs1_data);
        dec.src2     = BUNDLE_XLEN'(rs2_data);
        dec.rd_addr  = in_inst[11:7];
        dec.rd_sel   = RD_SEL_ALU;
        dec.lsu_op   = funct3;
        dec.csr_addr = in_inst[31:20];
        dec.csr_sel  = funct3;
        case (opcode)
            OP_LUI: begin
                dec.src1   = BUNDLE_XLEN'(in_pc);
                dec.src2   = BUNDLE_XLEN'(imm);
                alu_op     = ALU_OP_W'(ALU_LUI);
                dec.rd_wen = 1'b1;
            end
            OP_AUIPC: begin
                dec.src1   = BUNDLE_XLEN'(in_pc);
                dec.src2   = BUNDLE_XLEN'(imm);
                dec.rd_wen = 1'b1;
            end
            OP_JAL: begin
                dec.src1    = BUNDLE_XLEN'(in_pc);
                dec.src2    = BUNDLE_XLEN'(3'd4);
                dec.rd_wen  = 1'b1;
                dec.is_jump = 1'b1;
            end
            OP_JALR: begin
                dec.src2    = BUNDLE_XLEN'(3'd4);
                dec.rd_wen  = 1'b1;
                dec.is_jump = 1'b1;
            end
            OP_BRANCH: begin
                dec.is_branch = 1'b1;
                alu_op = funct3[2] ? (funct3[1] ? ALU_OP_W'(ALU_SLTU) : ALU_OP_W'(ALU_SLT))
                                   : ALU_OP_W'(ALU_SUB);
            end
            OP_LOAD: begin
                dec.src2    = BUNDLE_XLEN'(imm);
                dec.lsu_ren = 1'b1;
                dec.rd_wen  = 1'b1;
                dec.rd_sel  = RD_SEL_LSU;
            end
            OP_STORE: begin
                dec.src2    = BUNDLE_XLEN'(imm);
                dec.lsu_wen = 1'b1;
            end
            OP_IMM: begin
                dec.src2   = BUNDLE_XLEN'(imm);
                dec.rd_wen = 1'b1;
                alu_op     = ALU_OP_W'(alu_from_funct3(funct3, (funct3 == 3'd5) && in_inst[30]));
            end
            OP_REG: begin
                dec.rd_wen = 1'b1;
                alu_op     = ALU_OP_W'(alu_from_funct3(funct3, in_inst[30]));
            end
            OP_SYSTEM: begin
                dec.src2     = BUNDLE_XLEN'(imm);
                dec.rd_sel   = RD_SEL_CSR;
                dec.csr_wen  = (funct3 != 3'd0);
                dec.rd_wen   = (funct3 != 3'd0);
                dec.is_ecall = (in_inst == INST_ECALL);
                dec.is_mret  = (in_inst == INST_MRET);
            end
            OP_FENCE: begin
                dec.src2 = BUNDLE_XLEN'(imm);
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
        dec.alu_op = ALU_OP_MAX_W'(alu_op);
    end

    pipe_state_e    state_q, state_d;
    decode_bundle_t m_q, m_d;
    logic           out_valid_q;
    logic [1:0]     out_count_q;
    logic [1:0]     count_d;
    logic           in_fire;
    logic           out_fire;

`ifdef IDU_PIPE_SKID_EN
    decode_bundle_t s_q, s_d;
    logic           in_ready_q;

    assign in_ready = in_ready_q;
`else
    assign in_ready = ~out_valid_q | out_ready;
`endif

    assign in_fire    = in_valid & in_ready & ~flush;
    assign out_fire   = out_valid_q & out_ready;
    assign out_valid  = out_valid_q;
    assign out_count  = out_count_q;
    assign out_bundle = m_q;

    // Next-state and entry movement; flush overrides every handshake.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
`ifdef IDU_PIPE_SKID_EN
        s_d     = s_q;
`endif
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    m_d     = dec;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    m_d = dec;
                end
`ifdef IDU_PIPE_SKID_EN
                else if (in_fire) begin
                    s_d     = dec;
                    state_d = ST_FULL;
                end
`endif
                else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
`ifdef IDU_PIPE_SKID_EN
            ST_FULL: begin
                if (out_fire) begin
                    m_d     = s_q;
                    s_d     = '0;
                    state_d = ST_ONE;
                end
            end
`endif
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
            m_d     = '0;
`ifdef IDU_PIPE_SKID_EN
            s_d     = '0;
`endif
        end
        count_d = (state_d == ST_FULL) ? 2'd2 : ((state_d == ST_ONE) ? 2'd1 : 2'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            m_q         <= '0;
            out_valid_q <= 1'b0;
            out_count_q <= 2'd0;
`ifdef IDU_PIPE_SKID_EN
            s_q         <= '0;
            in_ready_q  <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            out_valid_q <= (state_d != ST_EMPTY);
            out_count_q <= count_d;
`ifdef IDU_PIPE_SKID_EN
            s_q         <= s_d;
            in_ready_q  <= (state_d != ST_FULL);
`endif
        end
    end

endmodule

// File: tb/tb_idu_pipe.sv
// Directed and randomized checks of idu_pipe against a queue-based reference
// model; a second XLEN=64 instance covers wide immediate extension.
module tb_idu_pipe;
    import idu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0]    in_inst, in_pc, rs1_data, rs2_data;
    logic [4:0]     rs1_addr, rs2_addr;
    decode_bundle_t out_bundle;
    logic [1:0]     out_count;

    logic           d1_in_valid, d1_in_ready, d1_out_valid;
    logic [31:0]    d1_in_inst;
    logic [63:0]    d1_in_pc;
    logic [4:0]     d1_rs1_addr, d1_rs2_addr;
    decode_bundle_t d1_out_bundle;
    logic [1:0]     d1_out_count;
    localparam logic [63:0] D1_RS1 = 64'hDEAD_BEEF_0000_1111;
    localparam logic [63:0] D1_RS2 = 64'h0123_4567_89AB_CDEF;

    logic [31:0] rf [32];
    assign rs1_data = rf[rs1_addr];
    assign rs2_data = rf[rs2_addr];

    idu_pipe #(.XLEN(32), .ALU_OP_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_bundle(out_bundle),
        .out_count(out_count)
    );

    idu_pipe #(.XLEN(64), .ALU_OP_W(4)) dut64 (
        .clk(clk), .rst(rst), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
        .in_inst(d1_in_inst), .in_pc(d1_in_pc), .rs1_addr(d1_rs1_addr), .rs2_addr(d1_rs2_addr),
        .rs1_data(D1_RS1), .rs2_data(D1_RS2), .flush(1'b0),
        .out_valid(d1_out_valid), .out_ready(1'b1), .out_bundle(d1_out_bundle),
        .out_count(d1_out_count)
    );

    int checks = 0;
    int failures = 0;
    decode_bundle_t q[$];

    task automatic chk_v(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input decode_bundle_t obs, input decode_bundle_t exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference decode written from the ISA field layout.
    function automatic decode_bundle_t ref_decode(input logic [31:0] inst, input logic [63:0] pc,
                                                  input logic [63:0] r1, input logic [63:0] r2,
                                                  input bit x64);
        decode_bundle_t b;
        logic [63:0] mask, i_imm, s_imm, b_imm, u_imm, j_imm;
        logic [3:0]  int_ops [8];
        logic [2:0]  f3;
        int_ops = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        f3    = inst[14:12];
        mask  = x64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        i_imm = {{52{inst[31]}}, inst[31:20]};
        s_imm = {{52{inst[31]}}, inst[31:25], inst[11:7]};
        b_imm = {{52{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        u_imm = {{32{inst[31]}}, inst[31:12], 12'h000};
        j_imm = {{44{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        b = '0;
        b.pc = pc; b.src1 = r1; b.src2 = r2;
        b.rd_addr = inst[11:7]; b.lsu_op = f3; b.csr_addr = inst[31:20]; b.csr_sel = f3;
        b.rd_sel = RD_SEL_ALU; b.alu_op = 8'(ALU_ADD);
        case (inst[6:0])
            OP_LUI:    begin b.imm = u_imm; b.src1 = pc; b.src2 = u_imm; b.alu_op = 8'(ALU_LUI); b.rd_wen = 1; end
            OP_AUIPC:  begin b.imm = u_imm; b.src1 = pc; b.src2 = u_imm; b.rd_wen = 1; end
            OP_JAL:    begin b.imm = j_imm; b.src1 = pc; b.src2 = 64'd4; b.rd_wen = 1; b.is_jump = 1; end
            OP_JALR:   begin b.imm = i_imm; b.src2 = 64'd4; b.rd_wen = 1; b.is_jump = 1; end
            OP_BRANCH: begin
                b.imm = b_imm; b.is_branch = 1;
                if (f3 == 3'd4 || f3 == 3'd5) b.alu_op = 8'(ALU_SLT);
                else if (f3 >= 3'd6)          b.alu_op = 8'(ALU_SLTU);
                else                          b.alu_op = 8'(ALU_SUB);
            end
            OP_LOAD:   begin b.imm = i_imm; b.src2 = i_imm; b.lsu_ren = 1; b.rd_wen = 1; b.rd_sel = RD_SEL_LSU; end
            OP_STORE:  begin b.imm = s_imm; b.src2 = s_imm; b.lsu_wen = 1; end
            OP_IMM, OP_REG: begin
                b.rd_wen = 1;
                b.alu_op = 8'(int_ops[f3]);
                if (inst[6:0] == OP_IMM) begin b.imm = i_imm; b.src2 = i_imm; end
                if (f3 == 3'd5 && inst[30]) b.alu_op = 8'(ALU_SRA);
                if (f3 == 3'd0 && inst[30] && inst[6:0] == OP_REG) b.alu_op = 8'(ALU_SUB);
            end
            OP_SYSTEM: begin
                b.imm = i_imm; b.src2 = i_imm; b.rd_sel = RD_SEL_CSR;
                b.csr_wen = (f3 != 0); b.rd_wen = (f3 != 0);
                b.is_ecall = (inst == 32'h0000_0073); b.is_mret = (inst == 32'h3020_0073);
            end
            OP_FENCE:  begin b.imm = i_imm; b.src2 = i_imm; end
            default:   b.illegal = 1;
        endcase
        b.pc &= mask; b.imm &= mask; b.src1 &= mask; b.src2 &= mask;
        return b;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r, res;
        r = $urandom;
        case ($urandom_range(0, 13))
            0:  res = {r[31:7], OP_LUI};
            1:  res = {r[31:7], OP_AUIPC};
            2:  res = {r[31:7], OP_JAL};
            3:  res = {r[31:7], OP_JALR};
            4:  res = {r[31:7], OP_BRANCH};
            5:  res = {r[31:7], OP_LOAD};
            6:  res = {r[31:7], OP_STORE};
            7:  res = {r[31:7], OP_IMM};
            8:  res = {r[31:7], OP_REG};
            9:  res = {r[31:7], OP_SYSTEM};
            10: res = {r[31:7], OP_FENCE};
            11: res = 32'h0000_0073;
            12: res = 32'h3020_0073;
            default: res = r;
        endcase
        return res;
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, advance.
    task automatic cycle(input logic iv, input logic [31:0] inst, input logic [31:0] pc,
                         input logic ordy, input logic fl, output logic acc);
        logic exp_ir;
        in_valid = iv; in_inst = inst; in_pc = pc; out_ready = ordy; flush = fl;
        #1;
`ifdef IDU_PIPE_SKID_EN
        exp_ir = (q.size() < 2);
`else
        exp_ir = (q.size() == 0) || ordy;
`endif
        chk_v("in_ready", 64'(in_ready), 64'(exp_ir));
        chk_v("out_valid", 64'(out_valid), 64'(q.size() != 0));
        chk_v("out_count", 64'(out_count), 64'(q.size()));
        chk_v("rs1_addr", 64'(rs1_addr), 64'(inst[19:15]));
        chk_v("rs2_addr", 64'(rs2_addr), 64'(inst[24:20]));
        if (q.size() != 0) chk_b("bundle", out_bundle, q[0]);
        acc = iv && exp_ir && !fl;
        if (fl) begin
            q.delete();
        end else begin
            if (q.size() != 0 && ordy) void'(q.pop_front());
            if (acc) q.push_back(ref_decode(inst, 64'(pc), 64'(rf[inst[19:15]]), 64'(rf[inst[24:20]]), 1'b0));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; d1_in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
    endtask

    task automatic chk_empty(input string tag);
        chk_v({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk_v({tag, "_count"}, 64'(out_count), 64'd0);
        chk_v({tag, "_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        acc, pend_v, ordy, fl;
        logic [31:0] pend_i, pend_pc;
        decode_bundle_t exp64;

        in_inst = '0; in_pc = '0; d1_in_inst = '0; d1_in_pc = '0;
        rf[0] = '0;
        for (int i = 1; i < 32; i++) rf[i] = $urandom;

        do_reset();
        do_reset();
        chk_empty("reset");
        chk_b("reset_bundle", out_bundle, decode_bundle_t'('0));

        // addi x1,x0,5 at 0x80000000
        cycle(1'b1, 32'h0050_0093, 32'h8000_0000, 1'b1, 1'b0, acc);
        chk_v("addi_valid", 64'(out_valid), 64'd1);
        chk_v("addi_src1", out_bundle.src1, 64'(rf[0]));
        chk_v("addi_src2", out_bundle.src2, 64'd5);
        chk_v("addi_rd", 64'(out_bundle.rd_addr), 64'd1);
        chk_v("addi_wen", 64'(out_bundle.rd_wen), 64'd1);
        chk_v("addi_count", 64'(out_count), 64'd1);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

        // Back-to-back words with downstream stalled
        cycle(1'b1, 32'h0011_0113, 32'h100, 1'b0, 1'b0, acc);
`ifdef IDU_PIPE_SKID_EN
        cycle(1'b1, 32'h0022_0213, 32'h104, 1'b0, 1'b0, acc);
        chk_v("stall_ready", 64'(in_ready), 64'd0);
        chk_v("stall_count", 64'(out_count), 64'd2);
        cycle(1'b1, 32'h0033_0313, 32'h108, 1'b0, 1'b0, acc);
        chk_v("third_held", 64'(acc), 64'd0);
        cycle(1'b1, 32'h0033_0313, 32'h108, 1'b1, 1'b0, acc);
        cycle(1'b1, 32'h0033_0313, 32'h108, 1'b1, 1'b0, acc);
`else
        chk_v("stall_ready", 64'(in_ready), 64'd0);
        cycle(1'b1, 32'h0022_0213, 32'h104, 1'b0, 1'b0, acc);
        chk_v("second_held", 64'(acc), 64'd0);
        cycle(1'b1, 32'h0022_0213, 32'h104, 1'b1, 1'b0, acc);
        cycle(1'b1, 32'h0033_0313, 32'h108, 1'b1, 1'b0, acc);
`endif
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
        chk_empty("drained");

        // Flush while full with a word offered
        cycle(1'b1, 32'h0040_0413, 32'h200, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h0050_0513, 32'h204, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h0060_0613, 32'h208, 1'b0, 1'b1, acc);
        chk_empty("flush");
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
        chk_v("flush_nothing", 64'(out_valid), 64'd0);

        // Illegal all-ones word
        cycle(1'b1, 32'hFFFF_FFFF, 32'h300, 1'b1, 1'b0, acc);
        chk_v("ill_flag", 64'(out_bundle.illegal), 64'd1);
        chk_v("ill_rd_wen", 64'(out_bundle.rd_wen), 64'd0);
        chk_v("ill_lsu_wen", 64'(out_bundle.lsu_wen), 64'd0);
        chk_v("ill_csr_wen", 64'(out_bundle.csr_wen), 64'd0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

        // Reset in the middle of a transfer
        cycle(1'b1, 32'h0070_0713, 32'h400, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h0080_0813, 32'h404, 1'b0, 1'b0, acc);
        do_reset();
        chk_empty("midrst");
        chk_b("midrst_bundle", out_bundle, decode_bundle_t'('0));
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

        // XLEN=64: lui x2,0x80000
        d1_in_valid = 1'b1; d1_in_inst = 32'h8000_0137; d1_in_pc = 64'h0000_0001_2345_6780;
        @(posedge clk);
        #1;
        d1_in_valid = 1'b0;
        exp64 = ref_decode(32'h8000_0137, 64'h0000_0001_2345_6780, D1_RS1, D1_RS2, 1'b1);
        chk_v("x64_valid", 64'(d1_out_valid), 64'd1);
        chk_v("x64_imm", d1_out_bundle.imm, 64'hFFFF_FFFF_8000_0000);
        chk_v("x64_src1", d1_out_bundle.src1, 64'h0000_0001_2345_6780);
        chk_v("x64_alu", 64'(d1_out_bundle.alu_op), 64'(ALU_LUI));
        chk_b("x64_bundle", d1_out_bundle, exp64);

        // Random valid/ready/flush traffic
        pend_v = 1'b0; pend_i = '0; pend_pc = '0;
        for (int c = 0; c < 10000; c++) begin
            if (!pend_v && $urandom_range(0, 9) < 7) begin
                pend_v  = 1'b1;
                pend_i  = rand_inst();
                pend_pc = $urandom & 32'hFFFF_FFFC;
            end
            ordy = ($urandom_range(0, 9) < 6);
            fl   = ($urandom_range(0, 199) == 0);
            cycle(pend_v, pend_v ? pend_i : $urandom, pend_pc, ordy, fl, acc);
            if (acc || fl) pend_v = 1'b0;
        end
        for (int c = 0; c < 4; c++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
        chk_empty("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/idu_pipe.md
IDU_PIPE -- requirements
Module: idu_pipe

Interface
REQ-001 Parameter XLEN, default 32, sets the data and PC width; legal values are 32 and 64.
REQ-002 Parameter ALU_OP_W, default 4, sets the ALU opcode width.
REQ-003 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, synchronous active-high reset.
REQ-005 Port in_valid, input, 1, upstream fetch word is valid.
REQ-006 Port in_ready, output, 1, idu_pipe accepts a word this cycle.
REQ-007 Port in_inst, input, 32, instruction word.
REQ-008 Port in_pc, input, XLEN, instruction PC.
REQ-009 Port rs1_addr and rs2_addr, output, 5 each, combinational from the instruction currently being decoded.
REQ-010 Port rs1_data and rs2_data, input, XLEN each, asynchronous register-file read data.
REQ-011 Port flush, input, 1, kills all held and incoming instructions.
REQ-012 Port out_valid, output, 1, decoded bundle is valid.
REQ-013 Port out_ready, input, 1, downstream accepts the bundle.
REQ-014 Port out_bundle, output, decode_bundle_t (package), holds pc, imm, src1, src2, alu_op, rd_addr, rd_wen, rd_sel, lsu_ren, lsu_wen, lsu_op, csr_addr, csr_wen, csr_sel, is_ecall, is_mret, is_branch, is_jump and illegal.
REQ-015 Port out_count, output, 2, number of occupied entries.

Function
REQ-016 Handshake fires on valid&ready, independently on each side; valid shall not drop and payload shall not change while valid&~ready.
REQ-017 Decode (immediate generation, src1/src2 selection, control fields) is combinational on the accepted word; the bundle is captured at the same edge on which the input handshake fires, giving 1-cycle latency.
REQ-018 src1 = pc for U/J-type, else rs1_data; src2 = imm for I/L/S/U, 4 for JAL/JALR, else rs2_data.
REQ-019 illegal = 1 for any opcode[6:0] outside RV32I+Zicsr+ecall/mret, or inst[1:0] != 2'b11; illegal bundles carry rd_wen = lsu_wen = lsu_ren = csr_wen = 0.
REQ-020 Storage is a 2-entry skid buffer: main entry M and skid entry S; out_bundle always comes from M.
REQ-021 States: EMPTY (count 0), ONE (M full), FULL (M and S full).
REQ-022 Transitions: EMPTY->ONE on in-fire; ONE->ONE on in-fire&out-fire or no fire; ONE->EMPTY on out-fire&~in-fire; ONE->FULL on in-fire&~out-fire; FULL->ONE on out-fire (S moves to M).
REQ-023 in_ready = (state != FULL), taken from a register, with no combinational path from out_ready.
REQ-024 flush sets state EMPTY on the next edge; an in_valid in the flush cycle is dropped; out_valid = 0 the following cycle.
REQ-025 flush has priority over every simultaneous handshake.
REQ-026 rs1_addr/rs2_addr = inst[19:15]/inst[24:20] of the word presented on in_inst.
REQ-027 Immediate sign extension fills bits XLEN-1:31 with inst[31].

Reset
REQ-028 rst sets state EMPTY, out_valid 0, in_ready 1, out_count 0 and out_bundle all-zero on the next edge.
REQ-029 rst mid-transfer drops both entries; nothing is replayed.

Configuration
REQ-030 With IDU_PIPE_SKID_EN defined, REQ-020..023 apply.
REQ-031 Without IDU_PIPE_SKID_EN there is a single entry M, in_ready = ~out_valid | out_ready (combinational), state FULL is unreachable, and out_count is at most 1.

Structure
REQ-032 Package idu_pkg holds decode_bundle_t, the opcode localparams (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_SYSTEM), the alu_op encodings and the rd_sel encoding (ALU/LSU/CSR).
REQ-033 Sub-module idu_imm_gen (combinational, XLEN-parametrised) produces imm; all storage stays in idu_pipe.

Verification
REQ-034 Reset, then addi x1,x0,5 (0x00500093) at pc 0x80000000 with out_ready = 1 -> next cycle out_valid = 1, src1 = rs1_data, src2 = 5, rd_addr = 1, rd_wen = 1, out_count = 1.
REQ-035 out_ready = 0, three back-to-back words offered -> first two accepted, in_ready = 0 after the second, the third is held upstream; raise out_ready -> bundles emerge in order, no loss or duplication.
REQ-036 FULL state with flush = 1 and in_valid = 1 -> next cycle out_valid = 0, out_count = 0, in_ready = 1; the flush-cycle word never appears.
REQ-037 Word 0xFFFFFFFF -> illegal = 1, rd_wen = 0, lsu_wen = 0, csr_wen = 0.
REQ-038 XLEN = 64, lui x2,0x80000 -> imm = 0xFFFFFFFF80000000, src1 = pc, alu_op = LUI encoding.
REQ-039 Random valid/ready toggling for 10k cycles with and without IDU_PIPE_SKID_EN -> scoreboard matches, and out_bundle is stable whenever out_valid&~out_ready.
